// File: rtl/dfg_table_writer.sv
// -----------------------------------------------------------------------------
// dfg_table_writer
//
// Loads DFG entries into a data table and per-set descriptors into a pointer
// table. After reset an INIT sweep clears every pointer line and data line 0.
// Entries then stream in as beats; each accepted beat is written straight
// through to the next free data line. A beat flagged i_last closes the current
// set, and the following COMMIT cycle writes {set base line, entry count} to
// the set's pointer line. i_finish closes loading. Overflow of either table,
// or a finish request in the middle of a set, ends in a sticky error.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   i_valid, o_ready  - entry beat handshake
//   i_addr, i_data_init, i_data_end - entry fields (N_ADDR_WIDTH each)
//   i_last            - beat is the last entry of the current set
//   i_finish          - single-cycle request to close loading
//   o_data_we/waddr/wdata - data table write port, wdata = {addr, init, end}
//   o_ptr_we/waddr/wdata  - pointer table write port, wdata = {ptr, count}
//   o_done, o_error   - sticky completion / failure flags
//   o_set_count       - number of committed sets
// -----------------------------------------------------------------------------
module dfg_table_writer #(
    parameter int N_ADDR_WIDTH = 32,
    parameter int N_DATA_LINES = 10,
    parameter int N_PTR_LINES  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [N_ADDR_WIDTH-1:0]   i_addr,
    input  logic [N_ADDR_WIDTH-1:0]   i_data_init,
    input  logic [N_ADDR_WIDTH-1:0]   i_data_end,
    input  logic                      i_last,
    input  logic                      i_finish,
    output logic                      o_data_we,
    output logic [7:0]                o_data_waddr,
    output logic [3*N_ADDR_WIDTH-1:0] o_data_wdata,
    output logic                      o_ptr_we,
    output logic [7:0]                o_ptr_waddr,
    output logic [15:0]               o_ptr_wdata,
    output logic                      o_done,
    output logic                      o_error,
    output logic [7:0]                o_set_count
);

    typedef enum logic [2:0] {
        S_INIT,
        S_ACCEPT,
        S_COMMIT,
        S_DONE,
        S_ERROR
    } state_t;

    // wr_ptr and set_idx carry a ninth bit so a 256-line table can still be
    // recognised as full before the 8-bit line index would wrap.
    localparam logic [8:0] DATA_END  = 9'(N_DATA_LINES);
    localparam logic [8:0] PTR_END   = 9'(N_PTR_LINES);
    localparam logic [7:0] INIT_LAST = 8'(N_PTR_LINES - 1);

    state_t     state;
    logic [8:0] wr_ptr;
    logic [8:0] set_idx;
    logic [7:0] set_base;
    logic [7:0] set_cnt;
    logic [7:0] init_idx;

    logic handshake;
    logic data_full;
    logic ptr_full;

    // Reset masks the state decode so nothing is written or accepted while
    // rst is high, even if the state register still holds COMMIT or ACCEPT.
    assign o_ready     = !rst && (state == S_ACCEPT);
    assign handshake   = i_valid && o_ready;
    assign data_full   = (wr_ptr == DATA_END);
    assign ptr_full    = (set_idx == PTR_END);
    assign o_set_count = set_idx[7:0];

    // Both table write ports are decoded from the current state and inputs so
    // an accepted beat lands in the data table in the same cycle.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        o_data_we    = 1'b0;
        o_data_waddr = '0;
        o_data_wdata = '0;
        o_ptr_we     = 1'b0;
        o_ptr_waddr  = '0;
        o_ptr_wdata  = '0;
        case (state)
            S_INIT: begin
                if (!rst) begin
                    o_ptr_we    = 1'b1;
                    o_ptr_waddr = init_idx;
                    // Data line 0 is the reserved all-zero line.
                    o_data_we   = (init_idx == 8'd0);
                end
            end
            S_ACCEPT: begin
                if (handshake && !data_full) begin
                    o_data_we    = 1'b1;
                    o_data_waddr = wr_ptr[7:0];
                    o_data_wdata = {i_addr, i_data_init, i_data_end};
                end
            end
            S_COMMIT: begin
                if (!rst && !ptr_full) begin
                    o_ptr_we    = 1'b1;
                    o_ptr_waddr = set_idx[7:0];
                    o_ptr_wdata = {set_base, set_cnt};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            state    <= S_INIT;
            wr_ptr   <= 9'd1;
            set_base <= 8'd1;
            set_idx  <= '0;
            set_cnt  <= '0;
            init_idx <= '0;
            o_done   <= 1'b0;
            o_error  <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (init_idx == INIT_LAST) begin
                        state <= S_ACCEPT;
                    end else begin
                        init_idx <= init_idx + 8'd1;
                    end
                end
                S_ACCEPT: begin
                    if (handshake) begin
                        if (data_full) begin
                            state   <= S_ERROR;
                            o_error <= 1'b1;
                        end else begin
                            wr_ptr  <= wr_ptr + 9'd1;
                            set_cnt <= set_cnt + 8'd1;
                            if (i_last) begin
                                state <= S_COMMIT;
                            end
                        end
                    end else if (i_finish) begin
                        // Finishing with a partially loaded set is a protocol error.
                        if (set_cnt == 8'd0) begin
                            state  <= S_DONE;
                            o_done <= 1'b1;
                        end else begin
                            state   <= S_ERROR;
                            o_error <= 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    if (ptr_full) begin
                        state   <= S_ERROR;
                        o_error <= 1'b1;
                    end else begin
                        set_idx  <= set_idx + 9'd1;
                        set_base <= wr_ptr[7:0];
                        set_cnt  <= '0;
                        state    <= S_ACCEPT;
                    end
                end
                default: ;  // DONE and ERROR hold until reset
            endcase
        end
    end

endmodule

// File: tb/tb_dfg_table_writer.sv
// -----------------------------------------------------------------------------
// tb_dfg_table_writer
//
// Per-cycle directed vectors: each record holds the inputs for one clock cycle
// and the expected outputs observed in that cycle. Records are built at the
// start of the run, then applied and compared in one loop. Write addresses and
// data are compared only where the matching write enable is expected high.
// -----------------------------------------------------------------------------
module tb_dfg_table_writer;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [AW-1:0] i_addr;
    logic [AW-1:0] i_data_init;
    logic [AW-1:0] i_data_end;
    logic          i_last;
    logic          i_finish;
    logic          o_data_we;
    logic [7:0]    o_data_waddr;
    logic [3*AW-1:0] o_data_wdata;
    logic          o_ptr_we;
    logic [7:0]    o_ptr_waddr;
    logic [15:0]   o_ptr_wdata;
    logic          o_done;
    logic          o_error;
    logic [7:0]    o_set_count;

    always #5 clk = ~clk;

    dfg_table_writer #(
        .N_ADDR_WIDTH(AW),
        .N_DATA_LINES(10),
        .N_PTR_LINES (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_addr      (i_addr),
        .i_data_init (i_data_init),
        .i_data_end  (i_data_end),
        .i_last      (i_last),
        .i_finish    (i_finish),
        .o_data_we   (o_data_we),
        .o_data_waddr(o_data_waddr),
        .o_data_wdata(o_data_wdata),
        .o_ptr_we    (o_ptr_we),
        .o_ptr_waddr (o_ptr_waddr),
        .o_ptr_wdata (o_ptr_wdata),
        .o_done      (o_done),
        .o_error     (o_error),
        .o_set_count (o_set_count)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic        last;
        logic        finish;
        logic [7:0]  tag;
        logic        ready;
        logic        dwe;
        logic [7:0]  dwaddr;
        logic        pwe;
        logic [7:0]  pwaddr;
        logic [15:0] pwdata;
        logic        done;
        logic        error;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3*AW-1:0] entry_of(input logic [7:0] tag);
        return {32'h1000_0000 | 32'(tag), 32'h2000_0000 | 32'(tag), 32'h3000_0000 | 32'(tag)};
    endfunction

    task automatic add(input logic r, v, l, f, input logic [7:0] tag,
                       input logic rdy, dwe, input logic [7:0] dwa,
                       input logic pwe, input logic [7:0] pwa, input logic [15:0] pwd,
                       input logic dn, er, input logic [7:0] cnt);
        vec_t x;
        x.rst = r; x.valid = v; x.last = l; x.finish = f; x.tag = tag;
        x.ready = rdy; x.dwe = dwe; x.dwaddr = dwa;
        x.pwe = pwe; x.pwaddr = pwa; x.pwdata = pwd;
        x.done = dn; x.error = er; x.cnt = cnt;
        vecs.push_back(x);
    endtask

    // Six sweep cycles: ptr line k cleared; data line 0 cleared in cycle 0.
    task automatic add_init();
        for (int k = 0; k < 6; k++)
            add(0, 0, 0, 0, 0, 0, k == 0, 8'd0, 1, 8'(k), 16'h0000, 0, 0, 8'd0);
    endtask

    // Accepted beat written to data line == tag.
    task automatic add_beat(input logic [7:0] tag, input logic last, input logic finish,
                            input logic [7:0] cnt);
        add(0, 1, last, finish, tag, 1, 1, tag, 0, 0, 16'h0000, 0, 0, cnt);
    endtask

    task automatic add_commit(input logic [7:0] line, input logic [15:0] pwd,
                              input logic [7:0] cnt);
        add(0, 0, 0, 0, 0, 0, 0, 8'd0, 1, line, pwd, 0, 0, cnt);
    endtask

    initial begin
        // --- Reset, INIT sweep, two sets, clean finish --------------------
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 8'd0);
        add(1, 1, 0, 1, 9, 0, 0, 0, 0, 0, 16'h0, 0, 0, 8'd0);
        add_init();
        add_beat(8'd1, 0, 0, 8'd0);
        add_beat(8'd2, 0, 0, 8'd0);
        add_beat(8'd3, 1, 0, 8'd0);
        add_commit(8'd0, 16'h0103, 8'd0);
        add_beat(8'd4, 1, 0, 8'd1);
        add_commit(8'd1, 16'h0401, 8'd1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0, 0, 0, 8'd2);      // idle
        add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 16'h0, 0, 0, 8'd2);      // finish
        add(0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 16'h0, 1, 0, 8'd2);      // DONE
        add(0, 1, 1, 1, 6, 0, 0, 0, 0, 0, 16'h0, 1, 0, 8'd2);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0, 8'd2);      // rst in DONE

        // --- Partial set then finish -> ERROR ------------------------------
        add_init();
        add_beat(8'd1, 0, 0, 8'd0);
        add_beat(8'd2, 0, 1, 8'd0);                                // finish ignored
        add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 16'h0, 0, 0, 8'd0);
        add(0, 1, 0, 1, 3, 0, 0, 0, 0, 0, 16'h0, 0, 1, 8'd0);      // ERROR
        add(0, 1, 1, 0, 4, 0, 0, 0, 0, 0, 16'h0, 0, 1, 8'd0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 1, 8'd0);      // rst in ERROR

        // --- Reset during COMMIT suppresses the ptr write -------------------
        add_init();
        add_beat(8'd1, 1, 0, 8'd0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 8'd0);

        // --- Data table overflow --------------------------------------------
        add_init();
        for (int j = 1; j <= 9; j++) add_beat(8'(j), 0, 0, 8'd0);
        add(0, 1, 0, 0, 10, 1, 0, 0, 0, 0, 16'h0, 0, 0, 8'd0);     // 10th beat: no write
        add(0, 1, 0, 0, 11, 0, 0, 0, 0, 0, 16'h0, 0, 1, 8'd0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 1, 8'd0);

        // --- Pointer table overflow: seven one-beat sets -------------------
        add_init();
        for (int j = 1; j <= 6; j++) begin
            add_beat(8'(j), 1, 0, 8'(j - 1));
            add_commit(8'(j - 1), {8'(j), 8'd1}, 8'(j - 1));
        end
        add_beat(8'd7, 1, 0, 8'd6);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 0, 8'd6);      // 7th COMMIT: no write
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 1, 8'd6);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 1, 8'd6);

        // --- One set then finish -> DONE with one set -----------------------
        add_init();
        add_beat(8'd1, 1, 0, 8'd0);
        add_commit(8'd0, 16'h0101, 8'd0);
        add(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 16'h0, 0, 0, 8'd1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 0, 8'd1);

        // --- Apply --------------------------------------------------------
        rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_finish = 1'b0;
        i_addr = '0; i_data_init = '0; i_data_end = '0;
        @(posedge clk);
        #1;
        for (int n = 0; n < vecs.size(); n++) begin
            logic [44:0] act;
            logic [44:0] exp;
            rst         = vecs[n].rst;
            i_valid     = vecs[n].valid;
            i_last      = vecs[n].last;
            i_finish    = vecs[n].finish;
            {i_addr, i_data_init, i_data_end} = entry_of(vecs[n].tag);
            @(negedge clk);
            act = {o_ready, o_data_we, o_data_we ? o_data_waddr : 8'd0,
                   o_ptr_we, o_ptr_we ? o_ptr_waddr : 8'd0, o_ptr_we ? o_ptr_wdata : 16'd0,
                   o_done, o_error, o_set_count};
            exp = {vecs[n].ready, vecs[n].dwe, vecs[n].dwaddr,
                   vecs[n].pwe, vecs[n].pwaddr, vecs[n].pwdata,
                   vecs[n].done, vecs[n].error, vecs[n].cnt};
            check($sformatf("vec%0d outputs", n), 128'(act), 128'(exp));
            if (vecs[n].dwe)
                check($sformatf("vec%0d data_wdata", n), 128'(o_data_wdata),
                      vecs[n].dwaddr == 8'd0 ? 128'd0 : 128'(entry_of(vecs[n].tag)));
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
